// File: rtl/nvram_seq_ctrl.sv
// Sequencer/arbiter for a 256x4 X2212-style NVRAM: CPU owns the RAM port while idle,
// the host streams images in (LOAD) or out (DUMP) through valid/ready channels.
module nvram_seq_ctrl #(
  parameter int AW             = 8,
  parameter int DW             = 4,
  parameter int STORE_AUTODUMP = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_di,
  output logic [DW-1:0] cpu_do,
  input  logic          cpu_ce_n,
  input  logic          cpu_rw_n,
  input  logic          cpu_recall_n,
  input  logic          cpu_store,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_i,
  input  logic [DW-1:0] ram_o,
  output logic          ram_ce_n,
  output logic          ram_rw_n,
  input  logic          host_load_start,
  input  logic          host_dump_start,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_wvalid,
  output logic          host_wready,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  input  logic          host_rready,
  output logic          recall_req,
  output logic          store_req,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_DUMP_RD   = 3'd2,
    S_DUMP_WAIT = 3'd3,
    S_DUMP_OUT  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          w_done_nxt;
  logic          r_done;
  logic [DW-1:0] r_rdata;
  logic          r_cpu_rd;
  logic          r_recall_n_d;
  logic          r_store_d;
  logic          r_recall_req;
  logic          r_store_req;
  logic          w_store_edge;
  logic          w_last;
  logic          w_idle;

  assign w_idle       = (r_state == S_IDLE);
  assign w_last       = (r_cnt == {AW{1'b1}});
  assign w_store_edge = cpu_store & ~r_store_d;

  // Both host channels use plain valid/ready: a beat transfers on a clock edge where
  // valid and ready are both high; the source holds its data stable until then.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (host_load_start) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = {AW{1'b0}};
        end else if (host_dump_start || ((STORE_AUTODUMP != 0) && w_store_edge)) begin
          w_state_nxt = S_DUMP_RD;
          w_cnt_nxt   = {AW{1'b0}};
        end
      end
      S_LOAD: begin
        if (host_wvalid) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_DUMP_RD:   w_state_nxt = S_DUMP_WAIT;
      S_DUMP_WAIT: w_state_nxt = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (host_rready) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DUMP_RD;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_a    = r_cnt;
    ram_i    = host_wdata;
    ram_ce_n = 1'b1;
    ram_rw_n = 1'b1;
    case (r_state)
      S_IDLE: begin
        ram_a    = cpu_a;
        ram_i    = cpu_di;
        ram_ce_n = cpu_ce_n;
        ram_rw_n = cpu_rw_n;
      end
      S_LOAD: begin
        ram_ce_n = ~host_wvalid;
        ram_rw_n = ~host_wvalid;
      end
      S_DUMP_RD: ram_ce_n = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= {AW{1'b0}};
      r_done       <= 1'b0;
      r_rdata      <= {DW{1'b0}};
      r_cpu_rd     <= 1'b0;
      r_recall_n_d <= 1'b1;
      r_store_d    <= 1'b0;
      r_recall_req <= 1'b0;
      r_store_req  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_done       <= w_done_nxt;
      r_recall_n_d <= cpu_recall_n;
      r_store_d    <= cpu_store;
      r_recall_req <= r_recall_n_d & ~cpu_recall_n;
      r_store_req  <= w_store_edge;
      r_cpu_rd     <= w_idle & ~cpu_ce_n & cpu_rw_n;
      if (r_state == S_DUMP_WAIT) r_rdata <= ram_o;
    end
  end

  // ram_o is only meaningful the cycle after an idle-state CPU read; otherwise float high.
  assign cpu_do      = (w_idle && r_cpu_rd) ? ram_o : {DW{1'b1}};
  assign host_wready = (r_state == S_LOAD);
  assign host_rvalid = (r_state == S_DUMP_OUT);
  assign host_rdata  = r_rdata;
  assign recall_req  = r_recall_req;
  assign store_req   = r_store_req;
  assign busy        = ~w_idle;
  assign done        = r_done;
  assign dbg_state   = r_state;

endmodule
